// File: rtl/router_merge_ctrl_pkg.sv
// Shared router constants, flit field helpers and merge-stage state type.
// Flit layout: [35:32] info, [31:16] tag, [15:0] value.
package router_merge_ctrl_pkg;

    localparam int ROUTER_WIDTH    = 36;
    localparam int MERGE_NUM_CHILD = 4;

    localparam logic [3:0] ROUTER_INFO_UV = 4'h2;

    localparam int DIR_NW = 0;
    localparam int DIR_NE = 1;
    localparam int DIR_SW = 2;
    localparam int DIR_SE = 3;

    localparam int ROUTER_INFO_HI = 35;
    localparam int ROUTER_INFO_LO = 32;
    localparam int ROUTER_TAG_HI  = 31;
    localparam int ROUTER_TAG_LO  = 16;
    localparam int ROUTER_VAL_HI  = 15;
    localparam int ROUTER_VAL_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } merge_state_t;

    function automatic logic [3:0] flit_info(input logic [ROUTER_WIDTH-1:0] f);
        return f[ROUTER_INFO_HI:ROUTER_INFO_LO];
    endfunction

    function automatic logic [15:0] flit_tag(input logic [ROUTER_WIDTH-1:0] f);
        return f[ROUTER_TAG_HI:ROUTER_TAG_LO];
    endfunction

    function automatic logic [15:0] flit_val(input logic [ROUTER_WIDTH-1:0] f);
        return f[ROUTER_VAL_HI:ROUTER_VAL_LO];
    endfunction

    function automatic logic [ROUTER_WIDTH-1:0] make_flit(input logic [3:0] info,
                                                          input logic [15:0] tag,
                                                          input logic [15:0] val);
        return {info, tag, val};
    endfunction

    function automatic logic [2:0] count_full(input logic [MERGE_NUM_CHILD-1:0] f);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < MERGE_NUM_CHILD; i++) c = c + {2'b00, f[i]};
        return c;
    endfunction

endpackage

// File: rtl/router_merge_slot.sv
// One child-direction holding slot: a full flag plus the captured flit.
// A load in the same cycle as a clear wins, so a set can refill while firing.
module router_merge_slot
    import router_merge_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_clear,
    input  logic                    i_flush,
    input  logic [ROUTER_WIDTH-1:0] i_data,
    output logic                    o_full,
    output logic [ROUTER_WIDTH-1:0] o_data,
    output logic                    o_ready_term
);

    logic                    r_full;
    logic [ROUTER_WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_full       = r_full;
    assign o_data       = r_data;
    assign o_ready_term = ~r_full;

endmodule

// File: rtl/router_merge_ctrl.sv
// Quadtree merge front-end: gathers one UV flit per child, then issues one
// summed flit from a registered valid/ready output.
module router_merge_ctrl
    import router_merge_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [MERGE_NUM_CHILD-1:0]              in_valid,
    input  logic [MERGE_NUM_CHILD*ROUTER_WIDTH-1:0] in_data,
    output logic [MERGE_NUM_CHILD-1:0]              in_ready,
    output logic                                    out_valid,
    output logic [ROUTER_WIDTH-1:0]                 out_data,
    input  logic                                    out_ready,
    input  logic                                    flush,
    output logic                                    busy,
    output logic                                    err_info,
    output logic                                    err_tag,
    output logic                                    err_timeout,
    output merge_state_t                            dbg_state
);

    // Handshake: a flit moves when valid & ready are both high at a rising
    // edge; out_data holds while out_valid & !out_ready.

    logic [MERGE_NUM_CHILD-1:0] w_full, w_ready_term, w_is_uv, w_load, w_full_next;
    logic [ROUTER_WIDTH-1:0]    w_slot_data [MERGE_NUM_CHILD];
    logic                       w_fire, w_tag_err;
    logic [15:0]                w_sum;
    logic [2:0]                 w_cnt_next;
    merge_state_t               r_state, w_state_next;
    logic [15:0]                r_wait;
    logic                       r_out_valid, r_err_info, r_err_tag, r_err_timeout;
    logic [ROUTER_WIDTH-1:0]    r_out_data;

    assign w_fire = (&w_full) & (~r_out_valid | out_ready) & ~flush;

    for (genvar g = 0; g < MERGE_NUM_CHILD; g++) begin : g_slot
        assign w_is_uv[g]  = flit_info(in_data[g*ROUTER_WIDTH +: ROUTER_WIDTH]) == ROUTER_INFO_UV;
        // A non-UV flit is refused outright rather than held.
        assign in_ready[g] = (w_ready_term[g] | w_fire) & ~flush & ~(in_valid[g] & ~w_is_uv[g]);
        assign w_load[g]   = in_valid[g] & in_ready[g];
        assign w_full_next[g] = flush ? 1'b0 : (w_load[g] | (w_full[g] & ~w_fire));

        router_merge_slot u_slot (
            .clk          (clk),
            .rst          (rst),
            .i_load       (w_load[g]),
            .i_clear      (w_fire),
            .i_flush      (flush),
            .i_data       (in_data[g*ROUTER_WIDTH +: ROUTER_WIDTH]),
            .o_full       (w_full[g]),
            .o_data       (w_slot_data[g]),
            .o_ready_term (w_ready_term[g])
        );
    end

    assign w_sum = flit_val(w_slot_data[DIR_NW]) + flit_val(w_slot_data[DIR_NE])
                 + flit_val(w_slot_data[DIR_SW]) + flit_val(w_slot_data[DIR_SE]);

    assign w_tag_err = (flit_tag(w_slot_data[DIR_NE]) != flit_tag(w_slot_data[DIR_NW]))
                     | (flit_tag(w_slot_data[DIR_SW]) != flit_tag(w_slot_data[DIR_NW]))
                     | (flit_tag(w_slot_data[DIR_SE]) != flit_tag(w_slot_data[DIR_NW]));

    assign w_cnt_next = count_full(w_full_next);

    // State tracks slot occupancy as it will be after this edge.
    always_comb begin
        w_state_next = ST_COLLECT;
        case (w_cnt_next)
            3'd0:    w_state_next = ST_IDLE;
            3'd4:    w_state_next = ST_FULL;
            default: w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (flush || (w_state_next != r_state)) begin
            r_wait <= '0;
        end else if ((r_state == ST_COLLECT) && (r_wait != 16'hFFFF)) begin
            r_wait <= r_wait + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= make_flit(ROUTER_INFO_UV, flit_tag(w_slot_data[DIR_NW]), w_sum);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_info    <= 1'b0;
            r_err_tag     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (|(in_valid & ~w_is_uv))
                r_err_info <= 1'b1;
            if (w_fire && w_tag_err)
                r_err_tag <= 1'b1;
            if ((r_state == ST_COLLECT) && (r_wait >= 16'(TIMEOUT - 1)))
                r_err_timeout <= 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign busy        = (|w_full) | r_out_valid;
    assign err_info    = r_err_info;
    assign err_tag     = r_err_tag;
    assign err_timeout = r_err_timeout;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_router_merge_ctrl.sv
// Bench for router_merge_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based merge model.
module tb_router_merge_ctrl;
    import router_merge_ctrl_pkg::*;

    localparam int TO = 8;
    localparam int W  = ROUTER_WIDTH;
    localparam int N  = MERGE_NUM_CHILD;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready = 1'b0;
    logic           flush = 1'b0;
    logic           busy, err_info, err_tag, err_timeout;
    merge_state_t   dbg_state;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] dq[N][$];
    logic         hold_prev = 1'b0;
    logic [W-1:0] hold_data = '0;

    router_merge_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .busy        (busy),
        .err_info    (err_info),
        .err_tag     (err_tag),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [15:0] tag, input logic [15:0] val);
        return {ROUTER_INFO_UV, tag, val};
    endfunction

    // Merged flit: UV info, NW tag, four values summed modulo 2^16.
    function automatic logic [W-1:0] ref_merge(input logic [W-1:0] nw, input logic [W-1:0] ne,
                                               input logic [W-1:0] sw, input logic [W-1:0] se);
        int s;
        s = int'(nw[15:0]) + int'(ne[15:0]) + int'(sw[15:0]) + int'(se[15:0]);
        return {ROUTER_INFO_UV, nw[31:16], 16'(s % 65536)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [N-1:0] v, input logic [W-1:0] f_nw, input logic [W-1:0] f_ne,
                          input logic [W-1:0] f_sw, input logic [W-1:0] f_se);
        in_valid = v;
        in_data[DIR_NW*W +: W] = f_nw;
        in_data[DIR_NE*W +: W] = f_ne;
        in_data[DIR_SW*W +: W] = f_sw;
        in_data[DIR_SE*W +: W] = f_se;
    endtask

    // Observes one cycle mid-period, updates the scoreboard, then advances.
    task automatic sb_cycle();
        logic [W-1:0] f [N];
        #1;
        if (hold_prev) chk("hold_stable", {out_valid, out_data}, {1'b1, hold_data});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL rand_extra observed=%0h expected=none", out_data);
            end else begin
                chk("rand_data", out_data, exp_q.pop_front());
            end
        end
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
        for (int d = 0; d < N; d++)
            if (in_valid[d] && in_ready[d]) dq[d].push_back(in_data[d*W +: W]);
        while (dq[0].size() > 0 && dq[1].size() > 0 && dq[2].size() > 0 && dq[3].size() > 0) begin
            for (int d = 0; d < N; d++) f[d] = dq[d].pop_front();
            exp_q.push_back(ref_merge(f[DIR_NW], f[DIR_NE], f[DIR_SW], f[DIR_SE]));
        end
        step();
    endtask

    initial begin
        logic [W-1:0] fl [N];
        logic [W-1:0] held;
        logic [N-1:0] v;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 4'hF);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_errs", {err_info, err_tag, err_timeout}, 3'b000);
        chk("rst_state", dbg_state, ST_IDLE);
        @(negedge clk) rst = 1'b1;
        step();

        // Simultaneous arrival
        out_ready = 1'b1;
        set_in(4'hF, mk(16'h00A5, 16'd1), mk(16'h00A5, 16'd2), mk(16'h00A5, 16'd3), mk(16'h00A5, 16'd4));
        step();
        set_in(4'h0, '0, '0, '0, '0);
        chk("sim_lat1_valid", out_valid, 1'b0);
        chk("sim_busy", busy, 1'b1);
        step();
        chk("sim_valid", out_valid, 1'b1);
        chk("sim_data", out_data, ref_merge(mk(16'h00A5, 1), mk(16'h00A5, 2), mk(16'h00A5, 3), mk(16'h00A5, 4)));
        step();
        chk("sim_drain", out_valid, 1'b0);

        // Staggered arrival: NW t0, SE t3, NE t5, SW t9
        for (int t = 0; t <= 11; t++) begin
            v = '0;
            v[DIR_NW] = (t == 0);
            v[DIR_SE] = (t == 3);
            v[DIR_NE] = (t == 5);
            v[DIR_SW] = (t == 9);
            set_in(v, mk(16'h0011, 16'd5), mk(16'h0011, 16'd6), mk(16'h0011, 16'd7), mk(16'h0011, 16'd8));
            #1;
            if (t >= 1 && t <= 9) chk("stag_nw_ready", in_ready[DIR_NW], 1'b0);
            if (t <= 10) chk("stag_no_out", out_valid, 1'b0);
            if (t == 11) chk("stag_out", {out_valid, out_data},
                             {1'b1, ref_merge(mk(16'h11, 5), mk(16'h11, 6), mk(16'h11, 7), mk(16'h11, 8))});
            step();
        end

        // Overflow then back-pressure with a second set queued
        out_ready = 1'b0;
        fl[0] = mk(16'h0000, 16'hFFFF);
        set_in(4'hF, fl[0], fl[0], fl[0], fl[0]);
        step();
        set_in(4'hF, mk(16'h0, 16'h100), mk(16'h0, 16'h200), mk(16'h0, 16'h300), mk(16'h0, 16'h400));
        #1;
        chk("ovf_ready_on_fire", in_ready, 4'hF);
        step();
        chk("ovf_data", {out_valid, out_data}, {1'b1, ref_merge(fl[0], fl[0], fl[0], fl[0])});
        held = out_data;
        set_in(4'hF, mk(16'h0, 16'h9), mk(16'h0, 16'h9), mk(16'h0, 16'h9), mk(16'h0, 16'h9));
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_low", in_ready, 4'h0);
            step();
            chk("bp_hold", {out_valid, out_data}, {1'b1, held});
        end
        chk("bp_state", dbg_state, ST_FULL);
        set_in(4'h0, '0, '0, '0, '0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'hF);
        step();
        chk("bp_second", {out_valid, out_data},
            {1'b1, ref_merge(mk(16'h0, 16'h100), mk(16'h0, 16'h200), mk(16'h0, 16'h300), mk(16'h0, 16'h400))});
        step();
        chk("bp_drain", out_valid, 1'b0);

        // Streaming: 16 back-to-back sets
        for (int i = 0; i <= 18; i++) begin
            if (i < 16) begin
                for (int d = 0; d < N; d++) fl[d] = mk(16'h0042, 16'($urandom));
                set_in(4'hF, fl[DIR_NW], fl[DIR_NE], fl[DIR_SW], fl[DIR_SE]);
                exp_q.push_back(ref_merge(fl[DIR_NW], fl[DIR_NE], fl[DIR_SW], fl[DIR_SE]));
            end else begin
                set_in(4'h0, '0, '0, '0, '0);
            end
            #1;
            if (i < 16) chk("strm_ready", in_ready, 4'hF);
            if (i >= 2 && i <= 17) chk("strm_out", {out_valid, out_data}, {1'b1, exp_q.pop_front()});
            if (i == 18) chk("strm_end", out_valid, 1'b0);
            step();
        end

        // Randomized traffic with back-pressure
        hold_prev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < N; d++) begin
                v[d]  = ($urandom_range(0, 3) != 0);
                fl[d] = mk(16'h0033, 16'($urandom));
            end
            set_in(v, fl[DIR_NW], fl[DIR_NE], fl[DIR_SW], fl[DIR_SE]);
            out_ready = ($urandom_range(0, 3) != 0);
            sb_cycle();
        end
        set_in(4'h0, '0, '0, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) sb_cycle();
        chk("rand_drained", exp_q.size(), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int d = 0; d < N; d++) dq[d].delete();
        chk("rand_idle", {busy, dbg_state}, {1'b0, ST_IDLE});
        chk("rand_no_errs", {err_info, err_tag}, 2'b00);

        // Non-UV flit on SW
        set_in(4'b0100, '0, '0, {4'hF, 16'h0, 16'h7}, '0);
        #1;
        chk("info_ready", in_ready, 4'b1011);
        step();
        set_in(4'h0, '0, '0, '0, '0);
        chk("info_err", {err_info, busy}, 2'b10);

        // Tag mismatch still merges
        set_in(4'hF, mk(16'h0, 16'd1), mk(16'h1, 16'd1), mk(16'h0, 16'd1), mk(16'h0, 16'd1));
        step();
        set_in(4'h0, '0, '0, '0, '0);
        chk("tag_before", err_tag, 1'b0);
        step();
        chk("tag_out", {out_valid, out_data},
            {1'b1, ref_merge(mk(16'h0, 1), mk(16'h1, 1), mk(16'h0, 1), mk(16'h0, 1))});
        chk("tag_err", err_tag, 1'b1);
        step();

        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        step();
        chk("rst2_errs", {err_info, err_tag, err_timeout}, 3'b000);

        // Timeout with only NW held
        set_in(4'b0001, mk(16'h5, 16'h5), '0, '0, '0);
        step();
        set_in(4'h0, '0, '0, '0, '0);
        chk("to_state", dbg_state, ST_COLLECT);
        for (int k = 1; k <= TO + 1; k++) begin
            step();
            chk("to_err", err_timeout, (k >= TO));
        end

        // Flush
        flush = 1'b1;
        set_in(4'b0010, '0, mk(16'h5, 16'h5), '0, '0);
        #1;
        chk("flush_ready", in_ready, 4'h0);
        step();
        flush = 1'b0;
        set_in(4'h0, '0, '0, '0, '0);
        #1;
        chk("flush_idle", {busy, dbg_state}, {1'b0, ST_IDLE});
        chk("flush_sticky", err_timeout, 1'b1);

        // Reset while FULL with output pending
        out_ready = 1'b0;
        set_in(4'hF, mk(16'h7, 16'h1), mk(16'h7, 16'h1), mk(16'h7, 16'h1), mk(16'h7, 16'h1));
        step();
        step();
        set_in(4'h0, '0, '0, '0, '0);
        #1;
        chk("full_state", {out_valid, dbg_state}, {1'b1, ST_FULL});
        rst = 1'b0;
        #1;
        chk("rst_full_out", {out_valid, out_data}, {1'b0, {W{1'b0}}});
        chk("rst_full_busy", {busy, in_ready}, {1'b0, 4'hF});
        @(negedge clk) rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
